issue_queue: RTL and testbench
==============================

Name: issue_queue

Overview:
- Unified 16-entry out-of-order issue queue between the 2-wide dispatch stage and the three functional units (FU0, FU1 = ALU; FU2 = MEM).
- Accepts up to two renamed micro-ops per cycle and tracks source readiness by physical-tag wakeup broadcasts.
- Each cycle, issues at most one oldest-ready op per FU.

Parameters:
- IQ_DEPTH, 16, number of entries (power of two, >=4).
- TAG_W, 6, physical register tag width (64 physical regs).
- IMM_W, 32, immediate width.
- NUM_WB, 3, number of writeback/wakeup broadcast ports.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous squash of all entries.
- disp_valid  in  2  per-slot dispatch valid; slot 0 is older.
- disp_ready  out  1  queue can take two ops this cycle.
- disp_opcode  in  2x7  per-slot opcode.
- disp_alu_op  in  2x3  per-slot ALU op.
- disp_use_imm  in  2  per-slot immediate select.
- disp_imm  in  2xIMM_W  per-slot immediate.
- disp_src1, disp_src2  in  2xTAG_W each  source physical tags.
- disp_src1_rdy, disp_src2_rdy  in  2 each  source ready from scoreboard; unused sources are presented as ready.
- disp_dest  in  2xTAG_W  destination physical tag.
- wb_valid  in  NUM_WB  wakeup broadcast valid.
- wb_tag  in  NUM_WBxTAG_W  completed destination tags.
- fu_ready  in  3  FU k can accept an op this cycle.
- iss_valid  out  3  issue to FU k (registered).
- iss_opcode  out  3x7  issued opcode.
- iss_alu_op  out  3x3  issued ALU op.
- iss_use_imm  out  3  issued immediate select.
- iss_imm  out  3xIMM_W  issued immediate.
- iss_src1, iss_src2, iss_dest  out  3xTAG_W each  issued tags.
- iq_count  out  $clog2(IQ_DEPTH+1)  occupied entries.

Behaviour:
- Reset (rst_n=0 at edge): all entry valid bits and the age matrix cleared; iss_valid=0; all iss_* fields=0; iq_count=0. disp_ready is combinational and reads 1 after reset.
- disp_ready = (IQ_DEPTH - iq_count) >= 2. It uses current occupancy only; entries freed by this cycle's issue are reusable next cycle.
- Slot k is accepted when disp_valid[k] & disp_ready & ~flush. It is allocated to the lowest-index free entry; slot 1 takes the next free entry. disp_valid=2'b10 is legal and allocates one entry.
- Allocation-time readiness: src_rdy = disp_srcN_rdy OR (any wb_valid[j] with wb_tag[j]==disp_srcN in the same cycle), so no wakeup is missed.
- Wakeup: every valid entry with a matching unready source sets src_rdy at the edge.
- Age matrix: older[i][j] marks entry i older than entry j.
  - On allocating entry n, every currently valid entry becomes older than n.
  - Slot 0 is older than slot 1.
- Eligibility: entry valid & src1_rdy & src2_rdy, where rdy is registered state.
- FU class: opcode 7'b0000011 or 7'b0100011 → MEM; all others → ALU.
- Select:
  - FU0 gets the oldest eligible ALU entry.
  - FU1 gets the oldest eligible ALU entry excluding FU0's pick.
  - FU2 gets the oldest eligible MEM entry.
  - A pick is made only if fu_ready[k]=1; otherwise the entry stays.
- Issue: the selected entry's fields are registered onto iss_* at the edge, iss_valid[k]=1, and the entry is freed at the same edge. iss_valid[k]=0 in any cycle with no pick.
- Latency: an op dispatched at edge t with both sources ready produces iss_valid after edge t+1 (one cycle in queue). A wakeup at edge w makes the entry issuable at edge w+1.
- iq_count(next) = iq_count + accepted − issued; it never exceeds IQ_DEPTH.
- flush: clears all entries and iss_valid at the edge; it takes priority over dispatch, wakeup and issue.
- Reset mid-operation: same effect as reset; no partial state survives.
- Empty queue: no iss_valid. Full or one entry free: disp_ready=0.

Optional Feature:
- Macro: IQ_WAKEUP_BYPASS_EN.
- Defined: eligibility also ORs in same-cycle wb_tag matches, so a broadcast at edge w lets the consumer issue at edge w (back-to-back dependent issue).
- Undefined: eligibility uses registered readiness only, as above.

Decomposition:
- Shared package rezzmaster holds:
  - iq_entry_t struct (valid, opcode, alu_op, use_imm, imm, src1/src2 + rdy, dest).
  - issue_pkt_t struct.
  - fu_class_t enum {FU_ALU, FU_MEM}.
  - OPC_LOAD and OPC_STORE constants.
- One sub-module: iq_age_select. Inputs are a request vector and the age matrix; outputs are a one-hot oldest grant. It is instantiated three times, with FU1's request masked by FU0's grant.

Test Plan:
- Reset then idle → iq_count=0, disp_ready=1, iss_valid=3'b000.
- Dispatch ALU add (src1=p5 rdy, src2=p6 rdy, dest=p40) at edge t → iss_valid[0]=1, iss_dest=40 after edge t+1, iq_count back to 0.
- Dispatch op with src1=p41 unready, then wb_valid[0]=1 / wb_tag=41 at edge w → issues at edge w+1 (macro off) or edge w (macro on).
- Fill 14 entries, all with unready sources → disp_ready=1. Dispatch 2 more → iq_count=16, disp_ready=0, and the next disp_valid=2'b11 is ignored.
- Three ready ALU ops A, B, C dispatched in order, plus one ready load → one edge issues A→FU0, B→FU1, load→FU2. C issues at the next edge on FU0.
- fu_ready=3'b000 with 4 ready entries → no issue, count holds. Assert flush → iq_count=0 and iss_valid=0 at the next edge.

Source files
------------

// File: rtl/rezzmaster.sv
// rtl/rezzmaster.sv - shared types and constants for the issue queue
//
// Purpose: entry and issue-packet layouts, FU class encoding and the
// memory opcodes that steer an op to the MEM functional unit.
// Ports: none (package).
package rezzmaster;

  localparam int PKG_TAG_W = 6;
  localparam int PKG_IMM_W = 32;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic {
    FU_ALU = 1'b0,
    FU_MEM = 1'b1
  } fu_class_t;

  typedef struct packed {
    logic                 valid;
    logic [6:0]           opcode;
    logic [2:0]           alu_op;
    logic                 use_imm;
    logic [PKG_IMM_W-1:0] imm;
    logic [PKG_TAG_W-1:0] src1;
    logic                 src1_rdy;
    logic [PKG_TAG_W-1:0] src2;
    logic                 src2_rdy;
    logic [PKG_TAG_W-1:0] dest;
  } iq_entry_t;

  typedef struct packed {
    logic [6:0]           opcode;
    logic [2:0]           alu_op;
    logic                 use_imm;
    logic [PKG_IMM_W-1:0] imm;
    logic [PKG_TAG_W-1:0] src1;
    logic [PKG_TAG_W-1:0] src2;
    logic [PKG_TAG_W-1:0] dest;
  } issue_pkt_t;

  function automatic fu_class_t fu_class(input logic [6:0] opcode);
    return (opcode == OPC_LOAD || opcode == OPC_STORE) ? FU_MEM : FU_ALU;
  endfunction

endpackage

// File: rtl/iq_age_select.sv
// rtl/iq_age_select.sv - one-hot grant of the oldest requesting entry
//
// Purpose: picks the oldest requester using the age matrix.
// Ports:
//   req   - per-entry request vector
//   older - flattened age matrix, bit i*N+j set when entry i is older than j
//   grant - one-hot (or zero) grant to the oldest requester
module iq_age_select #(
  parameter int N = 16
) (
  input  logic [N-1:0]   req,
  input  logic [N*N-1:0] older,
  output logic [N-1:0]   grant
);

  // An entry wins when no other requester is older than it.
  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = req[i];
      for (int j = 0; j < N; j++) begin
        if (req[j] && older[j*N+i]) grant[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - 16-entry out-of-order issue queue, 2-wide dispatch, 3 FUs
//
// Purpose: holds renamed ops until their sources are ready, then issues the
// oldest ready op to each of FU0/FU1 (ALU) and FU2 (MEM).
// Optional build macro IQ_WAKEUP_BYPASS_EN: same-cycle wakeup tags count
// toward eligibility, allowing back-to-back dependent issue.
// Ports:
//   clk, rst_n, flush          - clock, sync active-low reset, squash
//   disp_*                     - two dispatch slots (slot 0 older), disp_ready
//   wb_valid, wb_tag           - wakeup broadcasts
//   fu_ready                   - per-FU accept
//   iss_*                      - registered issue packets per FU
//   iq_count                   - occupied entries
module issue_queue
  import rezzmaster::*;
#(
  parameter int IQ_DEPTH = 16,
  parameter int TAG_W    = PKG_TAG_W,
  parameter int IMM_W    = PKG_IMM_W,
  parameter int NUM_WB   = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [1:0]                    disp_valid,
  output logic                          disp_ready,
  input  logic [13:0]                   disp_opcode,
  input  logic [5:0]                    disp_alu_op,
  input  logic [1:0]                    disp_use_imm,
  input  logic [2*IMM_W-1:0]            disp_imm,
  input  logic [2*TAG_W-1:0]            disp_src1,
  input  logic [2*TAG_W-1:0]            disp_src2,
  input  logic [1:0]                    disp_src1_rdy,
  input  logic [1:0]                    disp_src2_rdy,
  input  logic [2*TAG_W-1:0]            disp_dest,
  input  logic [NUM_WB-1:0]             wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]       wb_tag,
  input  logic [2:0]                    fu_ready,
  output logic [2:0]                    iss_valid,
  output logic [20:0]                   iss_opcode,
  output logic [8:0]                    iss_alu_op,
  output logic [2:0]                    iss_use_imm,
  output logic [3*IMM_W-1:0]            iss_imm,
  output logic [3*TAG_W-1:0]            iss_src1,
  output logic [3*TAG_W-1:0]            iss_src2,
  output logic [3*TAG_W-1:0]            iss_dest,
  output logic [$clog2(IQ_DEPTH+1)-1:0] iq_count
);

  localparam int IDX_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = $clog2(IQ_DEPTH+1);

  iq_entry_t                    ent_q   [IQ_DEPTH];
  logic [IQ_DEPTH-1:0]          older_q [IQ_DEPTH];
  logic [IQ_DEPTH-1:0]          older_d [IQ_DEPTH];
  logic [IQ_DEPTH*IQ_DEPTH-1:0] older_flat;
  logic [IQ_DEPTH-1:0]          hit1, hit2, elig, alu_req, mem_req, issued;
  logic [IQ_DEPTH-1:0]          req     [3];
  logic [IQ_DEPTH-1:0]          grant   [3];
  issue_pkt_t                   pick_pkt [3];
  issue_pkt_t                   iss_q    [3];
  iq_entry_t                    new_ent  [2];
  logic [1:0]                   accept;
  logic [IDX_W-1:0]             free0, free1;
  logic [IDX_W-1:0]             slot_idx [2];
  logic                         found0, found1;
  logic [1:0]                   acc_n, iss_n;
  logic [CNT_W-1:0]             count_q;

  function automatic logic wb_match(input logic [TAG_W-1:0] tag,
                                    input logic [NUM_WB-1:0] v,
                                    input logic [NUM_WB*TAG_W-1:0] t);
    logic m;
    m = 1'b0;
    for (int j = 0; j < NUM_WB; j++) begin
      if (v[j] && t[j*TAG_W +: TAG_W] == tag) m = 1'b1;
    end
    return m;
  endfunction

  assign disp_ready = (count_q <= CNT_W'(IQ_DEPTH - 2));
  assign accept     = disp_valid & {2{disp_ready & ~flush}};
  assign iq_count   = count_q;

  // Incoming entries; a broadcast in the allocation cycle is folded in here.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      new_ent[s].valid    = 1'b1;
      new_ent[s].opcode   = disp_opcode[s*7 +: 7];
      new_ent[s].alu_op   = disp_alu_op[s*3 +: 3];
      new_ent[s].use_imm  = disp_use_imm[s];
      new_ent[s].imm      = disp_imm[s*IMM_W +: IMM_W];
      new_ent[s].src1     = disp_src1[s*TAG_W +: TAG_W];
      new_ent[s].src2     = disp_src2[s*TAG_W +: TAG_W];
      new_ent[s].dest     = disp_dest[s*TAG_W +: TAG_W];
      new_ent[s].src1_rdy = disp_src1_rdy[s] |
                            wb_match(disp_src1[s*TAG_W +: TAG_W], wb_valid, wb_tag);
      new_ent[s].src2_rdy = disp_src2_rdy[s] |
                            wb_match(disp_src2[s*TAG_W +: TAG_W], wb_valid, wb_tag);
    end
  end

  // Two lowest free entries; slot 1 falls back to the first when slot 0 is idle.
  always_comb begin
    free0  = '0;
    free1  = '0;
    found0 = 1'b0;
    found1 = 1'b0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      if (!ent_q[i].valid) begin
        if (!found0) begin
          free0  = IDX_W'(i);
          found0 = 1'b1;
        end else if (!found1) begin
          free1  = IDX_W'(i);
          found1 = 1'b1;
        end
      end
    end
    slot_idx[0] = free0;
    slot_idx[1] = accept[0] ? free1 : free0;
  end

  // A new entry is younger than everything valid; its stale row is cleared.
  always_comb begin
    for (int i = 0; i < IQ_DEPTH; i++) older_d[i] = older_q[i];
    if (accept[0]) begin
      older_d[slot_idx[0]] = '0;
      for (int i = 0; i < IQ_DEPTH; i++) older_d[i][slot_idx[0]] = ent_q[i].valid;
    end
    if (accept[1]) begin
      older_d[slot_idx[1]] = '0;
      for (int i = 0; i < IQ_DEPTH; i++)
        older_d[i][slot_idx[1]] = ent_q[i].valid |
                                  (accept[0] && IDX_W'(i) == slot_idx[0]);
    end
  end

  always_comb begin
    for (int i = 0; i < IQ_DEPTH; i++)
      for (int j = 0; j < IQ_DEPTH; j++)
        older_flat[i*IQ_DEPTH+j] = older_q[i][j];
  end

  always_comb begin
    for (int i = 0; i < IQ_DEPTH; i++) begin
      hit1[i] = wb_match(ent_q[i].src1, wb_valid, wb_tag);
      hit2[i] = wb_match(ent_q[i].src2, wb_valid, wb_tag);
`ifdef IQ_WAKEUP_BYPASS_EN
      elig[i] = ent_q[i].valid & (ent_q[i].src1_rdy | hit1[i]) &
                (ent_q[i].src2_rdy | hit2[i]);
`else
      elig[i] = ent_q[i].valid & ent_q[i].src1_rdy & ent_q[i].src2_rdy;
`endif
      mem_req[i] = elig[i] & (fu_class(ent_q[i].opcode) == FU_MEM);
      alu_req[i] = elig[i] & (fu_class(ent_q[i].opcode) == FU_ALU);
    end
  end

  assign req[0] = fu_ready[0] ? alu_req : '0;
  assign req[1] = fu_ready[1] ? (alu_req & ~grant[0]) : '0;
  assign req[2] = fu_ready[2] ? mem_req : '0;

  iq_age_select #(.N(IQ_DEPTH)) u_sel_fu0 (.req(req[0]), .older(older_flat), .grant(grant[0]));
  iq_age_select #(.N(IQ_DEPTH)) u_sel_fu1 (.req(req[1]), .older(older_flat), .grant(grant[1]));
  iq_age_select #(.N(IQ_DEPTH)) u_sel_fu2 (.req(req[2]), .older(older_flat), .grant(grant[2]));

  assign issued = grant[0] | grant[1] | grant[2];
  assign acc_n  = {1'b0, accept[0]} + {1'b0, accept[1]};
  assign iss_n  = {1'b0, |grant[0]} + {1'b0, |grant[1]} + {1'b0, |grant[2]};

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      pick_pkt[k] = '0;
      for (int i = 0; i < IQ_DEPTH; i++) begin
        if (grant[k][i]) begin
          pick_pkt[k].opcode  = ent_q[i].opcode;
          pick_pkt[k].alu_op  = ent_q[i].alu_op;
          pick_pkt[k].use_imm = ent_q[i].use_imm;
          pick_pkt[k].imm     = ent_q[i].imm;
          pick_pkt[k].src1    = ent_q[i].src1;
          pick_pkt[k].src2    = ent_q[i].src2;
          pick_pkt[k].dest    = ent_q[i].dest;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q   <= '0;
      iss_valid <= '0;
      for (int k = 0; k < 3; k++) iss_q[k] <= '0;
      for (int i = 0; i < IQ_DEPTH; i++) begin
        ent_q[i].valid <= 1'b0;
        older_q[i]     <= '0;
      end
    end else if (flush) begin
      count_q   <= '0;
      iss_valid <= '0;
      for (int i = 0; i < IQ_DEPTH; i++) begin
        ent_q[i].valid <= 1'b0;
        older_q[i]     <= '0;
      end
    end else begin
      count_q <= count_q + CNT_W'(acc_n) - CNT_W'(iss_n);
      for (int k = 0; k < 3; k++) begin
        iss_valid[k] <= |grant[k];
        if (|grant[k]) iss_q[k] <= pick_pkt[k];
      end
      for (int i = 0; i < IQ_DEPTH; i++) begin
        older_q[i] <= older_d[i];
        if (ent_q[i].valid) begin
          if (hit1[i]) ent_q[i].src1_rdy <= 1'b1;
          if (hit2[i]) ent_q[i].src2_rdy <= 1'b1;
          if (issued[i]) ent_q[i].valid <= 1'b0;
        end
      end
      if (accept[0]) ent_q[slot_idx[0]] <= new_ent[0];
      if (accept[1]) ent_q[slot_idx[1]] <= new_ent[1];
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_out
    assign iss_opcode[k*7 +: 7]      = iss_q[k].opcode;
    assign iss_alu_op[k*3 +: 3]      = iss_q[k].alu_op;
    assign iss_use_imm[k]            = iss_q[k].use_imm;
    assign iss_imm[k*IMM_W +: IMM_W] = iss_q[k].imm;
    assign iss_src1[k*TAG_W +: TAG_W] = iss_q[k].src1;
    assign iss_src2[k*TAG_W +: TAG_W] = iss_q[k].src2;
    assign iss_dest[k*TAG_W +: TAG_W] = iss_q[k].dest;
  end

endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - self-checking bench for issue_queue
module tb_issue_queue;

  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic [1:0]  disp_valid;
  logic        disp_ready;
  logic [13:0] disp_opcode;
  logic [5:0]  disp_alu_op;
  logic [1:0]  disp_use_imm;
  logic [63:0] disp_imm;
  logic [11:0] disp_src1, disp_src2, disp_dest;
  logic [1:0]  disp_src1_rdy, disp_src2_rdy;
  logic [2:0]  wb_valid;
  logic [17:0] wb_tag;
  logic [2:0]  fu_ready;
  logic [2:0]  iss_valid;
  logic [20:0] iss_opcode;
  logic [8:0]  iss_alu_op;
  logic [2:0]  iss_use_imm;
  logic [95:0] iss_imm;
  logic [17:0] iss_src1, iss_src2, iss_dest;
  logic [4:0]  iq_count;

  always #5 clk = ~clk;

  issue_queue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_opcode(disp_opcode), .disp_alu_op(disp_alu_op),
    .disp_use_imm(disp_use_imm), .disp_imm(disp_imm),
    .disp_src1(disp_src1), .disp_src2(disp_src2),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_dest(disp_dest), .wb_valid(wb_valid), .wb_tag(wb_tag),
    .fu_ready(fu_ready), .iss_valid(iss_valid), .iss_opcode(iss_opcode),
    .iss_alu_op(iss_alu_op), .iss_use_imm(iss_use_imm), .iss_imm(iss_imm),
    .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_dest(iss_dest),
    .iq_count(iq_count)
  );

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  aop;
    logic        ui;
    logic [31:0] imm;
    logic [5:0]  s1;
    logic        r1;
    logic [5:0]  s2;
    logic        r2;
    logic [5:0]  d;
  } mop_t;

  // Reference queue kept in program order: index 0 is the oldest op.
  mop_t mq [$];
  int   n_checks = 0;
  int   n_errors = 0;

  localparam logic [6:0] ALU_R = 7'b0110011;
  localparam logic [6:0] ALU_I = 7'b0010011;
  localparam logic [6:0] LD    = 7'b0000011;
  localparam logic [6:0] ST    = 7'b0100011;
  logic [6:0] opc_tbl [4] = '{ALU_R, ALU_I, LD, ST};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic hit(input logic [5:0] t);
    logic h = 1'b0;
    for (int j = 0; j < 3; j++) if (wb_valid[j] && wb_tag[j*6 +: 6] == t) h = 1'b1;
    return h;
  endfunction

  function automatic logic is_mem(input logic [6:0] o);
    return (o == LD) || (o == ST);
  endfunction

  function automatic logic eligible(input mop_t m);
`ifdef IQ_WAKEUP_BYPASS_EN
    return (m.r1 | hit(m.s1)) & (m.r2 | hit(m.s2));
`else
    return m.r1 & m.r2;
`endif
  endfunction

  function automatic logic [63:0] pack(input mop_t m);
    return {3'b0, m.opc, m.aop, m.ui, m.imm, m.s1, m.s2, m.d};
  endfunction

  function automatic logic [63:0] dut_pkt(input int k);
    return {3'b0, iss_opcode[k*7 +: 7], iss_alu_op[k*3 +: 3], iss_use_imm[k],
            iss_imm[k*32 +: 32], iss_src1[k*6 +: 6], iss_src2[k*6 +: 6], iss_dest[k*6 +: 6]};
  endfunction

  function automatic mop_t slot_mop(input int s);
    mop_t m;
    m.opc = disp_opcode[s*7 +: 7];
    m.aop = disp_alu_op[s*3 +: 3];
    m.ui  = disp_use_imm[s];
    m.imm = disp_imm[s*32 +: 32];
    m.s1  = disp_src1[s*6 +: 6];
    m.s2  = disp_src2[s*6 +: 6];
    m.d   = disp_dest[s*6 +: 6];
    m.r1  = disp_src1_rdy[s] | hit(m.s1);
    m.r2  = disp_src2_rdy[s] | hit(m.s2);
    return m;
  endfunction

  task automatic idle();
    disp_valid = '0;
    flush      = 1'b0;
    wb_valid   = '0;
    wb_tag     = '0;
    fu_ready   = 3'b111;
  endtask

  task automatic put(input int s, input logic [6:0] opc, input logic [5:0] s1, input logic r1,
                     input logic [5:0] s2, input logic r2, input logic [5:0] d);
    disp_valid[s]          = 1'b1;
    disp_opcode[s*7 +: 7]  = opc;
    disp_alu_op[s*3 +: 3]  = 3'($urandom);
    disp_use_imm[s]        = 1'($urandom);
    disp_imm[s*32 +: 32]   = $urandom;
    disp_src1[s*6 +: 6]    = s1;
    disp_src1_rdy[s]       = r1;
    disp_src2[s*6 +: 6]    = s2;
    disp_src2_rdy[s]       = r2;
    disp_dest[s*6 +: 6]    = d;
  endtask

  // One clock of the reference model against the DUT; inputs stay stable.
  task automatic step();
    int   pick [3];
    mop_t exp_pkt [3];
    mop_t nm [2];
    mop_t keep [$];
    mop_t m;
    logic rdy_exp, fl;
    logic [1:0] acc;
    #1;
    rdy_exp = (D - mq.size()) >= 2;
    check("disp_ready", disp_ready, rdy_exp);
    fl  = flush;
    acc = disp_valid & {2{rdy_exp & ~fl}};
    for (int k = 0; k < 3; k++) pick[k] = -1;
    for (int i = 0; i < mq.size(); i++) begin
      if (eligible(mq[i])) begin
        if (is_mem(mq[i].opc)) begin
          if (fu_ready[2] && pick[2] < 0) pick[2] = i;
        end else if (fu_ready[0] && pick[0] < 0) pick[0] = i;
        else if (fu_ready[1] && pick[1] < 0) pick[1] = i;
      end
    end
    for (int k = 0; k < 3; k++) if (pick[k] >= 0) exp_pkt[k] = mq[pick[k]];
    for (int s = 0; s < 2; s++) nm[s] = slot_mop(s);
    for (int i = 0; i < mq.size(); i++) begin
      if (i != pick[0] && i != pick[1] && i != pick[2]) begin
        m = mq[i];
        m.r1 = m.r1 | hit(m.s1);
        m.r2 = m.r2 | hit(m.s2);
        keep.push_back(m);
      end
    end
    for (int s = 0; s < 2; s++) if (acc[s]) keep.push_back(nm[s]);
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
      for (int k = 0; k < 3; k++) pick[k] = -1;
    end else begin
      mq = keep;
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("fu%0d_valid", k), iss_valid[k], pick[k] >= 0);
      if (pick[k] >= 0) check($sformatf("fu%0d_pkt", k), dut_pkt(k), pack(exp_pkt[k]));
    end
    check("iq_count", iq_count, mq.size());
  endtask

  task automatic rand_inputs();
    idle();
    for (int s = 0; s < 2; s++)
      if ($urandom_range(0, 3) != 0)
        put(s, opc_tbl[$urandom_range(0, 3)], 6'($urandom), $urandom_range(0, 3) != 0,
            6'($urandom), $urandom_range(0, 3) != 0, 6'($urandom));
    for (int j = 0; j < 3; j++) begin
      wb_valid[j]      = 1'($urandom);
      wb_tag[j*6 +: 6] = 6'($urandom);
      fu_ready[j]      = $urandom_range(0, 3) != 0;
    end
    flush = ($urandom_range(0, 63) == 0);
  endtask

  initial begin
    rst_n = 1'b0;
    disp_opcode = '0; disp_alu_op = '0; disp_use_imm = '0; disp_imm = '0;
    disp_src1 = '0; disp_src2 = '0; disp_dest = '0;
    disp_src1_rdy = '0; disp_src2_rdy = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", iq_count, 0);
    check("rst_ready", disp_ready, 1);
    check("rst_iss_valid", iss_valid, 0);
    check("rst_iss_dest", iss_dest, 0);
    check("rst_iss_opcode", iss_opcode, 0);
    rst_n = 1'b1;
    step();

    // single ready ALU op: one cycle in the queue
    put(0, ALU_R, 6'd5, 1'b1, 6'd6, 1'b1, 6'd40);
    step();
    idle();
    step();
    check("add_valid", iss_valid, 3'b001);
    check("add_dest", iss_dest[5:0], 40);
    check("add_count", iq_count, 0);

    // wakeup latency
    put(0, ALU_R, 6'd41, 1'b0, 6'd6, 1'b1, 6'd7);
    step();
    idle();
    step();
    check("wake_wait", iss_valid, 3'b000);
    wb_valid[0] = 1'b1;
    wb_tag[5:0] = 6'd41;
    step();
`ifdef IQ_WAKEUP_BYPASS_EN
    check("wake_edge_w", iss_valid[0], 1);
`else
    check("wake_edge_w", iss_valid[0], 0);
`endif
    idle();
    step();
`ifdef IQ_WAKEUP_BYPASS_EN
    check("wake_edge_w1", iss_valid[0], 0);
`else
    check("wake_edge_w1", iss_valid[0], 1);
`endif

    // fill to 14, then 16, then try to overfill
    for (int c = 0; c < 7; c++) begin
      idle();
      put(0, ALU_R, 6'd60, 1'b0, 6'd61, 1'b0, 6'(2*c));
      put(1, ALU_R, 6'd60, 1'b0, 6'd61, 1'b0, 6'(2*c+1));
      step();
    end
    check("fill14_count", iq_count, 14);
    check("fill14_ready", disp_ready, 1);
    step();
    check("fill16_count", iq_count, 16);
    check("fill16_ready", disp_ready, 0);
    step();
    check("full_ignored", iq_count, 16);
    idle();
    flush = 1'b1;
    step();
    check("flush_count", iq_count, 0);

    // three ALU ops and a load, released together
    idle();
    fu_ready = 3'b000;
    put(0, ALU_R, 6'd1, 1'b1, 6'd2, 1'b1, 6'd10);
    put(1, ALU_I, 6'd1, 1'b1, 6'd2, 1'b1, 6'd11);
    step();
    put(0, ALU_R, 6'd1, 1'b1, 6'd2, 1'b1, 6'd12);
    put(1, LD,    6'd1, 1'b1, 6'd2, 1'b1, 6'd13);
    step();
    idle();
    step();
    check("sel3_valid", iss_valid, 3'b111);
    check("sel3_fu0", iss_dest[5:0], 10);
    check("sel3_fu1", iss_dest[11:6], 11);
    check("sel3_fu2", iss_dest[17:12], 13);
    step();
    check("selc_valid", iss_valid, 3'b001);
    check("selc_fu0", iss_dest[5:0], 12);

    // stalled FUs hold entries; flush empties
    idle();
    fu_ready = 3'b000;
    put(0, ALU_R, 6'd3, 1'b1, 6'd4, 1'b1, 6'd20);
    put(1, ST,    6'd3, 1'b1, 6'd4, 1'b1, 6'd21);
    step();
    put(0, ALU_R, 6'd3, 1'b1, 6'd4, 1'b1, 6'd22);
    put(1, LD,    6'd3, 1'b1, 6'd4, 1'b1, 6'd23);
    step();
    disp_valid = '0;
    step();
    check("stall_count", iq_count, 4);
    check("stall_valid", iss_valid, 3'b000);
    flush = 1'b1;
    step();
    check("stall_flush_count", iq_count, 0);
    check("stall_flush_valid", iss_valid, 3'b000);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      step();
    end

    // reset in the middle of traffic
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    mq.delete();
    check("midrst_count", iq_count, 0);
    check("midrst_valid", iss_valid, 3'b000);
    rst_n = 1'b1;
    for (int n = 0; n < 200; n++) begin
      rand_inputs();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
